// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC output path.
package cordic_pkg;

  localparam int unsigned CORDIC_DATA_WIDTH = 56;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with a registered occupancy count; head word is visible on o_data.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_async_rst,
  input  logic                           i_clr,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [WIDTH-1:0]               i_data,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_async_rst) begin
    if (!i_async_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (i_push && !i_pop)      r_count <= r_count + LW'(1);
      else if (!i_push && i_pop) r_count <= r_count - LW'(1);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == LW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;

endmodule

// File: rtl/cordic_out_serializer.sv
// Buffers CORDIC result words and emits each as LSB-first narrow beats on a valid/ready port.
module cordic_out_serializer
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CORDIC_DATA_WIDTH,
  parameter int unsigned BEAT_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                              i_clk,
  input  logic                              i_async_rst,
  input  logic                              i_en,
  input  logic                              i_clr,
  input  logic                              i_vld,
  input  logic [DATA_WIDTH-1:0]             i_data,
  output logic                              o_vld,
  output logic [BEAT_WIDTH-1:0]             o_data,
  output logic                              o_last,
  input  logic                              i_rdy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
  output logic                              o_ovf,
  output logic [CNT_WIDTH-1:0]              o_drop_cnt
);

  localparam int unsigned NUM_BEATS   = ceil_div(DATA_WIDTH, BEAT_WIDTH);
  localparam int unsigned SHIFT_WIDTH = NUM_BEATS * BEAT_WIDTH;
  localparam int unsigned BEAT_IDX_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(NUM_BEATS - 1);

  ser_state_t                             r_state;
  logic                                   r_vld;
  logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0]   r_shift;
  logic [BEAT_IDX_W-1:0]                  r_beat;
  logic                                   r_ovf;
  logic [CNT_WIDTH-1:0]                   r_drop_cnt;

  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_last_hs;
  logic                  w_pop;
  logic                  w_cap;
  logic                  w_push;
  logic                  w_drop;

  // A pop happens from IDLE, or back-to-back on the last-beat handshake.
  assign w_last_hs = r_vld & i_rdy & (r_beat == LAST_BEAT);
  assign w_pop     = !w_empty & ((r_state == IDLE) | w_last_hs);
  assign w_cap     = i_vld & i_en;
  assign w_push    = w_cap & (!w_full | w_pop);
  assign w_drop    = w_cap & w_full & !w_pop;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_async_rst (i_async_rst),
    .i_clr       (i_clr),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (i_data),
    .o_data      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (o_level)
  );

  always_ff @(posedge i_clk or negedge i_async_rst) begin
    if (!i_async_rst) begin
      r_state    <= IDLE;
      r_vld      <= 1'b0;
      r_shift    <= '0;
      r_beat     <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_clr) begin
      r_state    <= IDLE;
      r_vld      <= 1'b0;
      r_shift    <= '0;
      r_beat     <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= SHIFT_WIDTH'(w_head);
            r_beat  <= '0;
            r_vld   <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_rdy) begin
            if (r_beat == LAST_BEAT) begin
              r_beat <= '0;
              if (w_pop) begin
                r_shift <= SHIFT_WIDTH'(w_head);
              end else begin
                r_vld   <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_beat <= r_beat + BEAT_IDX_W'(1);
            end
          end
        end
        default: begin
          r_vld   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_vld      = r_vld;
  assign o_data     = r_shift[r_beat];
  assign o_last     = r_vld & (r_beat == LAST_BEAT);
  assign o_ovf      = r_ovf;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: doc/cordic_out_serializer.md
# cordic_out_serializer

Downstream stage of the CORDIC wrapper. It captures each `DATA_WIDTH`-bit result word the CORDIC presents on its `o_vld`/`o_data`, and buffers the words in a small FIFO. It then emits each word as a sequence of narrow `BEAT_WIDTH` beats on a valid/ready interface toward the pad-limited chip output or scan-out logic. The CORDIC has no backpressure, so words that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `DATA_WIDTH`, 56, width of one CORDIC result word
- `BEAT_WIDTH`, 8, output beat width; `NUM_BEATS = ceil(DATA_WIDTH/BEAT_WIDTH)` (7 at defaults)
- `FIFO_DEPTH`, 4, word entries in the FIFO (power of two, ≥2)
- `CNT_WIDTH`, 8, drop-counter width

Ports:
- `i_clk`  in  1  single clock, rising edge
- `i_async_rst`  in  1  reset; asynchronous assert, active-low (0 = reset)
- `i_en`  in  1  capture enable; when 0, incoming words are ignored and not counted as drops
- `i_clr`  in  1  synchronous clear of all state
- `i_vld`  in  1  word valid from the CORDIC (`o_vld`)
- `i_data`  in  `DATA_WIDTH`  word from the CORDIC (`o_data`)
- `o_vld`  out  1  beat valid
- `o_data`  out  `BEAT_WIDTH`  beat data
- `o_last`  out  1  marks the final beat of a word
- `i_rdy`  in  1  downstream ready
- `o_level`  out  `$clog2(FIFO_DEPTH+1)`  FIFO occupancy; excludes the word held in the shift register
- `o_ovf`  out  1  sticky; set on the first drop
- `o_drop_cnt`  out  `CNT_WIDTH`  dropped-word count, saturating

## Operation
- Write: a word is written when `i_vld & i_en & (!full | pop_this_cycle)`.
- Drop: if `i_vld & i_en & full & !pop_this_cycle`, the word is discarded. `o_drop_cnt` increments, saturating at all-ones, and `o_ovf` is set to 1.
- Serializer FSM:
  - IDLE: when the FIFO is non-empty, pop the head into the shift register, set `beat_idx`=0, and go to SHIFT.
  - SHIFT: `o_vld`=1 and `o_data` = shift register bits `[beat_idx*BEAT_WIDTH +: BEAT_WIDTH]`, LSB beat first.
  - When the final beat is not an exact fit, its unused MSBs are 0.
  - `o_last`=1 when `beat_idx == NUM_BEATS-1`.
  - On `o_vld & i_rdy`, `beat_idx` increments.
  - On the last-beat handshake: if the FIFO is non-empty, pop and load the next word on the same edge and stay in SHIFT with no bubble. Otherwise go to IDLE.
- Holding: while `o_vld & !i_rdy`, `o_data` and `o_last` hold stable.
- `i_en`=0 gates capture only; draining continues.
- `i_clr`=1: on the next edge, the FIFO, shift register, FSM (IDLE), `beat_idx`, `o_drop_cnt` and `o_ovf` all clear. `i_clr` has priority over a write or pop in the same cycle.
- Reset:
  - Asserted: all outputs are 0 (`o_vld`, `o_data`, `o_last`, `o_level`, `o_ovf`, `o_drop_cnt`) and the FSM is IDLE.
  - Mid-word: `o_vld` drops immediately, the partial word is lost, and no beat is replayed after release.

## Timing
- Latency: with `i_vld` sampled at edge N, the word is in the FIFO after N and loaded at edge N+1, so the first beat has `o_vld`=1 in the cycle after edge N+1 (2 cycles).
- Throughput: one beat per cycle while `i_rdy`=1. Sustained input rate without loss is one word per `NUM_BEATS` cycles.
- Full-and-pop: a write into a full FIFO is accepted when a pop occurs in the same cycle.
- All outputs are registered, except `o_data`/`o_last`, which are mux outputs of registered state.

## Structure
- `cordic_pkg`: `DATA_WIDTH` default and the FSM state enum (`IDLE`, `SHIFT`).
- Sub-module `sync_fifo` (parameterised width/depth, push/pop, full/empty/level). The serializer FSM and counters live in the top.
- Target size: ~200 lines of RTL.

## Test plan
- Single word: `i_data`=56'h01_2345_6789_ABCD, `i_rdy`=1 → 2 cycles later, beats CD, AB, 89, 67, 45, 23, 01 on consecutive cycles, with `o_last` only on 01.
- Back-to-back: 4 words 7 cycles apart, `i_rdy`=1 → 28 consecutive valid beats with no bubble, and `o_level` never exceeds 1.
- Overflow: `i_rdy`=0, 6 words on consecutive cycles → word 1 is in the shift register, `o_level`=4, word 6 is dropped, `o_drop_cnt`=1, `o_ovf`=1. Releasing `i_rdy` drains words 1–5 intact.
- Backpressure: random `i_rdy` toggling → `o_data`/`o_last` stable while stalled, and the beat sequence matches the single-word reference.
- Saturation/clear: 300 drops → `o_drop_cnt`=255. `i_clr` together with `i_vld` → all state is 0 and the word is not written.
- Reset mid-word: assert `i_async_rst`=0 during beat 3 → `o_vld`=0 immediately. After release, there is no output until a new word arrives.
